// File: rtl/adder_pipe_if.sv
// Operand/result stream bundle for adder_pipe: valid/ready on both the operand and the result side.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface adder_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, CHUNK bits per stage, carry registered between stages; latency STAGES.
// One global advance: when the output beat is held (out_valid && !out_ready) every stage freezes and in_ready drops.
module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic adv;
  logic out_vld;
  logic ovf_q;

  assign adv          = !out_vld || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // REM: operand bits still unprocessed on entry; DONE: sum bits complete on exit.
    localparam int REM  = WIDTH - k * CHUNK;
    localparam int DONE = (k + 1) * CHUNK;

    logic             vld_in;
    logic             c_in;
    logic [REM-1:0]   a_in;
    logic [REM-1:0]   b_in;
    logic [CHUNK:0]   slice;
    logic [DONE-1:0]  s_d;
    logic [DONE-1:0]  s_q;
    logic             vld_q;
    logic             c_q;

    if (k == 0) begin : g_head
      assign vld_in = bus.in_valid;
      assign a_in   = bus.a;
      assign b_in   = bus.sub ? ~bus.b : bus.b;
      assign c_in   = bus.sub ^ bus.cin;
      assign s_d    = slice[CHUNK-1:0];
    end else begin : g_body
      assign vld_in = g_stg[k-1].vld_q;
      assign a_in   = g_stg[k-1].g_fwd.a_q;
      assign b_in   = g_stg[k-1].g_fwd.b_q;
      assign c_in   = g_stg[k-1].c_q;
      assign s_d    = {slice[CHUNK-1:0], g_stg[k-1].s_q};
    end

    assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        c_q   <= slice[CHUNK];
        s_q   <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Upper operand slices ride along untouched until their stage consumes them.
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:CHUNK];
          b_q <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      logic ovf_d;

      assign ovf_d = a_in[REM-1] ^ b_in[REM-1] ^ slice[CHUNK-1] ^ slice[CHUNK];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_vld       = g_stg[STAGES-1].vld_q;
  assign bus.out_valid = out_vld;
  assign bus.sum       = g_stg[STAGES-1].s_q;
  assign bus.cout      = g_stg[STAGES-1].c_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (WIDTH=8, CHUNK=2): expected beats queued on accept, checked on emit.
module tb_adder_pipe;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(8)) bus ();

  adder_pipe #(.WIDTH(8), .CHUNK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Integer reference: true unsigned/signed results, cout = carry (add) or no-borrow (sub).
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int   ur;
    int   sr;
    exp_t e;
    if (sub) begin
      ur     = int'(a) - int'(b) - int'(cin);
      sr     = int'($signed(a)) - int'($signed(b)) - int'(cin);
      e.cout = (ur >= 0);
    end else begin
      ur     = int'(a) + int'(b) + int'(cin);
      sr     = int'($signed(a)) + int'($signed(b)) + int'(cin);
      e.cout = (ur > 255);
    end
    e.sum = 8'(ur);
    e.ovf = (sr > 127) || (sr < -128);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic ordy, input exp_t e);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.out_ready = ordy;
    #1;
    if (v && bus.in_ready) sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'($urandom);
    bus.a         = 8'($urandom);
    bus.b         = 8'($urandom);
    bus.cin       = 1'($urandom);
    bus.sub       = 1'($urandom);
    bus.out_ready = 1'($urandom);
    repeat (2) @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = 8'($urandom);
    bus.b         = 8'($urandom);
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
    vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end

    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e);
    rst_n = 1'b1;

    // Park a result at the output, then pull reset between clock edges.
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, model(8'hFF, 8'hFF, 1'b0, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, e);
      n++;
    end while (!bus.out_valid && n < 20);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL async_setup_valid: got %b want 1", bus.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL async_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.sum !== 8'h00) begin miscompares++; $display("FAIL async_sum: got %h want 00", bus.sum); end
    vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL async_cout: got %b want 0", bus.cout); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [7:0] t_a[2] = '{8'hFF, 8'h7F};
    logic [7:0] t_b[2] = '{8'hFF, 8'h01};
    exp_t       t_e[2] = '{'{8'hFE, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b1}};
    exp_t       e;
    int         lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, t_a[i], t_b[i], 1'b0, 1'b0, 1'b1, t_e[i]);
      lat = 0;
      do begin
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, t_e[i]);
        lat++;
      end while (!bus.out_valid && lat < 20);
      vectors++; if (lat != 4) begin miscompares++; $display("FAIL add_latency[%0d]: got %0d want 4", i, lat); end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL add_extra[%0d]: result %h with nothing pending", i, bus.sum); end
        else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== e) begin
            miscompares++;
            $display("FAIL add[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", i, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] t_a[3] = '{8'h05, 8'h80, 8'h10};
    logic [7:0] t_b[3] = '{8'h07, 8'h01, 8'h03};
    logic       t_c[3] = '{1'b0, 1'b0, 1'b1};
    exp_t       t_e[3] = '{'{8'hFE, 1'b0, 1'b0}, '{8'h7F, 1'b1, 1'b1}, '{8'h0C, 1'b1, 1'b0}};
    exp_t       e;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, t_a[i], t_b[i], t_c[i], 1'b1, 1'b1, t_e[i]);
      lat = 0;
      do begin
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, t_e[i]);
        lat++;
      end while (!bus.out_valid && lat < 20);
      vectors++; if (lat != 4) begin miscompares++; $display("FAIL sub_latency[%0d]: got %0d want 4", i, lat); end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL sub_extra[%0d]: result %h with nothing pending", i, bus.sum); end
        else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== e) begin
            miscompares++;
            $display("FAIL sub[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", i, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         got = 0;
    int         first = -1;
    int         last = -1;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       su;
    exp_t       e;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      @(negedge clk);
      if (sent < 10) begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        ci = sent[0];
        su = sent[1];
        drive(1'b1, a, b, ci, su, 1'b1, model(a, b, ci, su));
        if (bus.in_ready) sent++;
      end else begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e);
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        if (first < 0) first = cyc;
        last = cyc;
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL stream_extra: result %h with nothing pending", bus.sum); end
        else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== e) begin
            miscompares++;
            $display("FAIL stream[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", got - 1, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
    vectors++; if (got != 10) begin miscompares++; $display("FAIL stream_count: got %0d results want 10", got); end
    vectors++; if (last - first != 9) begin miscompares++; $display("FAIL stream_gapless: span %0d cycles want 9", last - first); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL stream_leftover: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         got = 0;
    logic       ordy;
    logic       stall;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       su;
    exp_t       e;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      stall = (cyc >= 4) && (cyc < 7);
      ordy  = !stall;
      if (sent < 8) begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        ci = 1'($urandom);
        su = 1'($urandom);
        drive(1'b1, a, b, ci, su, ordy, model(a, b, ci, su));
        if (bus.in_ready) sent++;
      end else begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy, e);
      end
      if (stall) begin
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b want 0", cyc, bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", cyc, bus.out_valid); end
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL stall_hold[%0d]: nothing pending", cyc); end
        else if ({bus.sum, bus.cout, bus.ovf} !== sb[0]) begin
          miscompares++;
          $display("FAIL stall_hold[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", cyc, bus.sum, bus.cout, bus.ovf, sb[0].sum, sb[0].cout, sb[0].ovf);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL bp_extra: result %h with nothing pending", bus.sum); end
        else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== e) begin
            miscompares++;
            $display("FAIL bp[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", got - 1, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
    vectors++; if (got != 8) begin miscompares++; $display("FAIL bp_count: got %0d results want 8", got); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL bp_leftover: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    exp_t       e;
    exp_t       want = '{8'h97, 1'b0, 1'b1};
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      drive(1'b1, a, b, 1'b0, 1'b0, 1'b1, model(a, b, 1'b0, 1'b0));
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stale[%0d]: out_valid %b want 0", i, bus.out_valid); end
    end
    @(negedge clk);
    drive(1'b1, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1, want);
    lat = 0;
    do begin
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e);
      lat++;
    end while (!bus.out_valid && lat < 20);
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL flush_latency: got %0d want 4", lat); end
    if (bus.out_valid && bus.out_ready) begin
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL flush_extra: result %h with nothing pending", bus.sum); end
      else begin
        e = sb.pop_front();
        if ({bus.sum, bus.cout, bus.ovf} !== e) begin
          miscompares++;
          $display("FAIL flush_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
